// File: rtl/cw305_pulpino_loader.sv
// PULPino data-memory loader: moves a pDATA_WIDTH block to/from RAM as 32-bit OBI beats, 2 cycles/beat minimum.
// Bus fields hold until I_gnt; starts while busy are dropped. `define CW305_LOADER_TIMEOUT_EN adds a watchdog abort.
module cw305_pulpino_loader #(
    parameter int          pDATA_WIDTH   = 128,
    parameter logic [31:0] pBASE_ADDR    = 32'h0010_0000,
    parameter int          pOFFSET_WIDTH = 16,
    parameter int          pTIMEOUT      = 1023
) (
    input  logic                     crypto_clk,
    input  logic                     reset_i,
    input  logic [pDATA_WIDTH-1:0]   I_block,
    input  logic [pOFFSET_WIDTH-1:0] I_offset,
    input  logic                     I_rd,
    input  logic                     I_start,
    output logic                     O_ready,
    output logic                     O_busy,
    output logic                     O_done,
    output logic                     O_error,
    output logic [pDATA_WIDTH-1:0]   O_rdata,
    output logic                     O_req,
    output logic                     O_we,
    output logic [3:0]               O_be,
    output logic [31:0]              O_addr,
    output logic [31:0]              O_wdata,
    input  logic                     I_gnt,
    input  logic                     I_rvalid,
    input  logic [31:0]              I_rdata
);

    localparam int NBEATS = pDATA_WIDTH / 32;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic                     start_q;
    logic [pDATA_WIDTH-1:0]   block_q, block_d;
    logic [pOFFSET_WIDTH-1:0] offset_q, offset_d;
    logic                     rd_q, rd_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [pDATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                     req_q, req_d;
    logic                     we_q, we_d;
    logic [3:0]               be_q, be_d;
    logic [31:0]              addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;

    logic              start_evt;
    logic              busy;
    logic              timeout;
    logic [BEAT_W-1:0] beat_nxt;

    // Offset arithmetic is confined to pOFFSET_WIDTH so the window wraps instead of carrying into the base.
    function automatic logic [31:0] beat_addr(input logic [pOFFSET_WIDTH-1:0] off,
                                              input logic [BEAT_W-1:0] b);
        logic [pOFFSET_WIDTH-1:0] w;
        w = off + pOFFSET_WIDTH'(b);
        return pBASE_ADDR + 32'({w, 2'b00});
    endfunction

    function automatic logic [31:0] beat_word(input logic [pDATA_WIDTH-1:0] blk,
                                              input logic [BEAT_W-1:0] b);
        return blk[{b, 5'd0} +: 32];
    endfunction

    assign start_evt = I_start & ~start_q;
    assign busy      = (state_q == S_REQ) || (state_q == S_RESP);
    assign beat_nxt  = beat_q + BEAT_W'(1);

`ifdef CW305_LOADER_TIMEOUT_EN
    localparam int WD_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT + 1) : 1;

    logic [WD_W-1:0] wdog_q, wdog_d;

    assign timeout = busy && (wdog_q == WD_W'(pTIMEOUT - 1));

    // Restarts on every REQ/RESP entry, so the limit applies per phase, not per block.
    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (busy) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // No watchdog in this build: the transfer waits on the bus indefinitely.
    assign timeout = (pTIMEOUT < 0);
`endif

    always_comb begin
        state_d  = state_q;
        block_d  = block_q;
        offset_d = offset_q;
        rd_d     = rd_q;
        beat_d   = beat_q;
        done_d   = done_q;
        error_d  = error_q;
        rdata_d  = rdata_q;
        req_d    = req_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start_evt) begin
                    block_d  = I_block;
                    offset_d = I_offset;
                    rd_d     = I_rd;
                    beat_d   = '0;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    req_d    = 1'b1;
                    we_d     = ~I_rd;
                    be_d     = 4'hF;
                    addr_d   = beat_addr(I_offset, '0);
                    wdata_d  = beat_word(I_block, '0);
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (I_gnt) begin
                    req_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (I_rvalid) begin
                    if (rd_q) begin
                        rdata_d[{beat_q, 5'd0} +: 32] = I_rdata;
                    end
                    if (beat_q == LAST_BEAT) begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        beat_d  = beat_nxt;
                        req_d   = 1'b1;
                        addr_d  = beat_addr(offset_q, beat_nxt);
                        wdata_d = beat_word(block_q, beat_nxt);
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            req_d   = 1'b0;
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            block_q  <= '0;
            offset_q <= '0;
            rd_q     <= 1'b0;
            beat_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= I_start;
            block_q  <= block_d;
            offset_q <= offset_d;
            rd_q     <= rd_d;
            beat_q   <= beat_d;
            done_q   <= done_d;
            error_q  <= error_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign O_ready = ~busy;
    assign O_busy  = busy;
    assign O_done  = done_q;
    assign O_error = error_q;
    assign O_rdata = rdata_q;
    assign O_req   = req_q;
    assign O_we    = we_q;
    assign O_be    = be_q;
    assign O_addr  = addr_q;
    assign O_wdata = wdata_q;

endmodule
